// File: rtl/ttl_shift_serializer.sv
// rtl/ttl_shift_serializer.sv - multi-plane PISO shift serializer with bit counter
//
// Ports:
//   CLK     rising-edge clock
//   RST     asynchronous active-high reset
//   CLRn    synchronous clear, active-low (overrides INH)
//   INH     clock inhibit, freezes registers and counter
//   SH_LDn  0 = parallel load, 1 = shift
//   FLIP    0 = shift toward MSB (Q from MSB), 1 = shift toward LSB (Q from LSB)
//   SER     serial fill bit per plane
//   D       parallel data, plane p at D[p*WIDTH +: WIDTH]
//   LATCH   shadow capture strobe (shadow build only)
//   Q       serial output per plane
//   QP      parallel register contents
//   CNT     valid bits remaining
//   LAST    CNT == 1
//   EMPTY   CNT == 0
//   SHV     shadow valid (shadow build only)
//
// Optional feature: define SHIFT_SHADOW_EN to build the per-plane shadow
// register with seamless reload when the last valid bit is shifted out.
module ttl_shift_serializer #(
  parameter  int WIDTH  = 8,
  parameter  int PLANES = 4,
  localparam int CW     = $clog2(WIDTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLRn,
  input  logic                      INH,
  input  logic                      SH_LDn,
  input  logic                      FLIP,
  input  logic [PLANES-1:0]         SER,
  input  logic [PLANES*WIDTH-1:0]   D,
  input  logic                      LATCH,
  output logic [PLANES-1:0]         Q,
  output logic [PLANES*WIDTH-1:0]   QP,
  output logic [CW-1:0]             CNT,
  output logic                      LAST,
  output logic                      EMPTY
`ifdef SHIFT_SHADOW_EN
  ,
  output logic                      SHV
`endif
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [PLANES*WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    shift_edge;
  logic                    reload;

  // A "shift edge" is any edge that would move data if no reload intervened.
  assign shift_edge = CLRn && !INH && SH_LDn;

`ifdef SHIFT_SHADOW_EN
  logic [PLANES*WIDTH-1:0] sh_q, sh_d;
  logic                    shv_q, shv_d;

  // Swap in the shadow exactly when the last valid bit leaves, so the
  // pixel stream continues without a gap.
  assign reload = shift_edge && (cnt_q == CNT_ONE) && shv_q;

  always_comb begin
    sh_d  = sh_q;
    shv_d = shv_q;
    if (!CLRn) begin
      shv_d = 1'b0;
    end else begin
      if (reload) begin
        shv_d = 1'b0;
      end
      // A capture on the reload edge refills the shadow, so it stays valid.
      if (LATCH) begin
        sh_d  = D;
        shv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_q  <= '0;
      shv_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      shv_q <= shv_d;
    end
  end

  assign SHV = shv_q;
`else
  logic unused_latch;
  assign unused_latch = LATCH;
  assign reload       = 1'b0;
`endif

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (!CLRn) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (!INH) begin
      if (!SH_LDn) begin
        sr_d  = D;
        cnt_d = CNT_FULL;
      end else if (reload) begin
`ifdef SHIFT_SHADOW_EN
        sr_d  = sh_q;
`endif
        cnt_d = CNT_FULL;
      end else begin
        for (int p = 0; p < PLANES; p++) begin
          if (FLIP) begin
            sr_d[p*WIDTH +: WIDTH] = {SER[p], sr_q[p*WIDTH+1 +: WIDTH-1]};
          end else begin
            sr_d[p*WIDTH +: WIDTH] = {sr_q[p*WIDTH +: WIDTH-1], SER[p]};
          end
        end
        // Serial fill keeps flowing after the counter bottoms out.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // Output tap follows FLIP combinationally so X-flip needs no extra cycle.
  always_comb begin
    Q = '0;
    for (int p = 0; p < PLANES; p++) begin
      Q[p] = FLIP ? sr_q[p*WIDTH] : sr_q[p*WIDTH + WIDTH - 1];
    end
  end

  assign QP    = sr_q;
  assign CNT   = cnt_q;
  assign LAST  = (cnt_q == CNT_ONE);
  assign EMPTY = (cnt_q == '0);

endmodule

// File: tb/tb_ttl_shift_serializer.sv
// tb/tb_ttl_shift_serializer.sv - self-checking bench for ttl_shift_serializer
module tb_ttl_shift_serializer;

  localparam int W  = 8;
  localparam int PL = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clrn = 1'b1;
  logic              inh = 1'b0;
  logic              sh_ldn = 1'b1;
  logic              flip = 1'b0;
  logic [PL-1:0]     ser = '0;
  logic [PL*W-1:0]   d = '0;
  logic              latch = 1'b0;
  logic [PL-1:0]     q;
  logic [PL*W-1:0]   qp;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              empty;
`ifdef SHIFT_SHADOW_EN
  logic              shv;
`endif

  int checks = 0;
  int errors = 0;

  ttl_shift_serializer #(.WIDTH(W), .PLANES(PL)) dut (
    .CLK(clk), .RST(rst), .CLRn(clrn), .INH(inh), .SH_LDn(sh_ldn),
    .FLIP(flip), .SER(ser), .D(d), .LATCH(latch),
    .Q(q), .QP(qp), .CNT(cnt), .LAST(last), .EMPTY(empty)
`ifdef SHIFT_SHADOW_EN
    , .SHV(shv)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one integer-like word per plane plus a bit count.
  bit [W-1:0] m_reg [PL];
  int         m_cnt;
`ifdef SHIFT_SHADOW_EN
  bit [W-1:0] m_sh [PL];
  bit         m_shv;
`endif

  task automatic model_reset();
    for (int p = 0; p < PL; p++) m_reg[p] = '0;
    m_cnt = 0;
`ifdef SHIFT_SHADOW_EN
    for (int p = 0; p < PL; p++) m_sh[p] = '0;
    m_shv = 1'b0;
`endif
  endtask

  task automatic model_step();
    bit do_reload;
    do_reload = 1'b0;
    if (!clrn) begin
      for (int p = 0; p < PL; p++) m_reg[p] = '0;
      m_cnt = 0;
`ifdef SHIFT_SHADOW_EN
      m_shv = 1'b0;
`endif
      return;
    end
`ifdef SHIFT_SHADOW_EN
    do_reload = !inh && sh_ldn && (m_cnt == 1) && m_shv;
`endif
    if (!inh) begin
      if (!sh_ldn) begin
        for (int p = 0; p < PL; p++) m_reg[p] = d[p*W +: W];
        m_cnt = W;
      end else if (do_reload) begin
`ifdef SHIFT_SHADOW_EN
        for (int p = 0; p < PL; p++) m_reg[p] = m_sh[p];
`endif
        m_cnt = W;
      end else begin
        for (int p = 0; p < PL; p++) begin
          if (flip) m_reg[p] = (m_reg[p] >> 1) | (W'(ser[p]) << (W - 1));
          else      m_reg[p] = (m_reg[p] << 1) | W'(ser[p]);
        end
        m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      end
    end
`ifdef SHIFT_SHADOW_EN
    if (do_reload) m_shv = 1'b0;
    if (latch) begin
      for (int p = 0; p < PL; p++) m_sh[p] = d[p*W +: W];
      m_shv = 1'b1;
    end
`endif
  endtask

  function automatic logic [PL*W-1:0] exp_qp();
    logic [PL*W-1:0] v;
    for (int p = 0; p < PL; p++) v[p*W +: W] = m_reg[p];
    return v;
  endfunction

  function automatic logic [PL-1:0] exp_q();
    logic [PL-1:0] v;
    for (int p = 0; p < PL; p++) v[p] = flip ? m_reg[p][0] : m_reg[p][W-1];
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (qp !== '0) begin errors++; $display("FAIL reset_qp: got %h want 0", qp); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++; if (empty !== 1'b1 || last !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b last=%b want 1/0", empty, last); end
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_q: got %b want 0", q); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_first();
    bit [7:0] s0, s1;
    s0 = 8'h9A; s1 = 8'h3C;
    flip = 1'b0; ser = '0; clrn = 1'b1; inh = 1'b0; latch = 1'b0;
    d = {8'h3C, 8'h9A}; sh_ldn = 1'b0;
    tick();
    sh_ldn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (q[0] !== s0[7-i]) begin errors++; $display("FAIL msb_q0[%0d]: got %b want %b", i, q[0], s0[7-i]); end
      checks++; if (q[1] !== s1[7-i]) begin errors++; $display("FAIL msb_q1[%0d]: got %b want %b", i, q[1], s1[7-i]); end
      checks++; if (cnt !== CW'(8 - i)) begin errors++; $display("FAIL msb_cnt[%0d]: got %0d want %0d", i, cnt, 8 - i); end
      checks++; if (last !== (i == 7)) begin errors++; $display("FAIL msb_last[%0d]: got %b want %b", i, last, (i == 7)); end
      checks++; if (qp !== exp_qp()) begin errors++; $display("FAIL msb_qp[%0d]: got %h want %h", i, qp, exp_qp()); end
      tick();
    end
    checks++; if (cnt !== '0 || empty !== 1'b1 || last !== 1'b0) begin errors++; $display("FAIL msb_end: cnt=%0d empty=%b last=%b want 0/1/0", cnt, empty, last); end
  endtask

  task automatic test_lsb_first();
    bit [7:0] s0;
    s0 = 8'h9A;
    flip = 1'b1; ser = '0;
    d = {8'h3C, 8'h9A}; sh_ldn = 1'b0;
    tick();
    sh_ldn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (q[0] !== s0[i]) begin errors++; $display("FAIL lsb_q0[%0d]: got %b want %b", i, q[0], s0[i]); end
      if (i == 1) begin
        checks++; if (qp[7:0] !== 8'h4D) begin errors++; $display("FAIL lsb_qp_after1: got %h want 4d", qp[7:0]); end
      end
      tick();
    end
    flip = 1'b0;
  endtask

  task automatic test_inhibit();
    bit [7:0] s0;
    s0 = 8'h9A;
    flip = 1'b0; ser = '0;
    d = {8'h3C, 8'h9A}; sh_ldn = 1'b0;
    tick();
    sh_ldn = 1'b1;
    tick();
    tick();
    inh = 1'b1; d = '0;
    for (int k = 0; k < 2; k++) begin
      sh_ldn = (k == 1);
      tick();
      checks++; if (qp[7:0] !== 8'h68) begin errors++; $display("FAIL inh_qp[%0d]: got %h want 68", k, qp[7:0]); end
      checks++; if (cnt !== CW'(6)) begin errors++; $display("FAIL inh_cnt[%0d]: got %0d want 6", k, cnt); end
    end
    inh = 1'b0; sh_ldn = 1'b1;
    for (int i = 2; i < 8; i++) begin
      checks++; if (q[0] !== s0[7-i]) begin errors++; $display("FAIL inh_resume[%0d]: got %b want %b", i, q[0], s0[7-i]); end
      tick();
    end
  endtask

  task automatic test_clear_and_async_reset();
    flip = 1'b0; ser = '0;
    d = {8'h3C, 8'h9A}; sh_ldn = 1'b0;
    tick();
    sh_ldn = 1'b1;
    tick(); tick(); tick();
    checks++; if (cnt !== CW'(5)) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 5", cnt); end
    clrn = 1'b0; inh = 1'b1;
    tick();
    checks++; if (qp !== '0 || cnt !== '0) begin errors++; $display("FAIL clr_under_inh: qp=%h cnt=%0d want 0/0", qp, cnt); end
    clrn = 1'b1; inh = 1'b0; sh_ldn = 1'b0; d = {8'hA5, 8'h5A};
    tick();
    sh_ldn = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (qp !== '0 || cnt !== '0 || q !== '0 || empty !== 1'b1 || last !== 1'b0) begin
      errors++; $display("FAIL async_rst: qp=%h cnt=%0d q=%b empty=%b last=%b", qp, cnt, q, empty, last);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_serial_fill();
    flip = 1'b0; sh_ldn = 1'b1; inh = 1'b0;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    ser = 2'b01;
    tick();
    ser = 2'b00;
    for (int i = 1; i < 8; i++) begin
      checks++; if (q[0] !== 1'b0 || cnt !== '0) begin errors++; $display("FAIL fill_early[%0d]: q0=%b cnt=%0d want 0/0", i, q[0], cnt); end
      tick();
    end
    checks++; if (q[0] !== 1'b1 || cnt !== '0) begin errors++; $display("FAIL fill_arrive: q0=%b cnt=%0d want 1/0", q[0], cnt); end
  endtask

  task automatic test_reload();
    bit [15:0] exp_seq;
`ifdef SHIFT_SHADOW_EN
    exp_seq = 16'b1111_1111_0000_1111;
`else
    exp_seq = 16'b1111_1111_0101_0101;
`endif
    flip = 1'b0; clrn = 1'b1; inh = 1'b0; ser = '0;
    d = {8'h00, 8'hFF}; sh_ldn = 1'b0;
    tick();
    sh_ldn = 1'b1;
    latch = 1'b1; d = {8'h00, 8'h0F};
    for (int i = 0; i < 16; i++) begin
      checks++; if (q[0] !== exp_seq[15-i]) begin errors++; $display("FAIL reload_q0[%0d]: got %b want %b", i, q[0], exp_seq[15-i]); end
      if (i == 8) begin
`ifdef SHIFT_SHADOW_EN
        checks++; if (cnt !== CW'(8) || shv !== 1'b0) begin errors++; $display("FAIL reload_cnt: cnt=%0d shv=%b want 8/0", cnt, shv); end
`else
        checks++; if (cnt !== '0) begin errors++; $display("FAIL reload_cnt: cnt=%0d want 0", cnt); end
`endif
      end
      ser[0] = i[0];
      tick();
      latch = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clrn   = ($urandom_range(0, 15) != 0);
      inh    = ($urandom_range(0, 3) == 0);
      sh_ldn = ($urandom_range(0, 4) != 0);
      flip   = 1'($urandom_range(0, 1));
      latch  = ($urandom_range(0, 3) == 0);
      ser    = PL'($urandom);
      d      = {$urandom, $urandom};
      #1;
      checks++; if (q !== exp_q()) begin errors++; $display("FAIL rnd_q_flip[%0d]: got %b want %b", n, q, exp_q()); end
      tick();
      checks++; if (qp !== exp_qp()) begin errors++; $display("FAIL rnd_qp[%0d]: got %h want %h", n, qp, exp_qp()); end
      checks++; if (cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, cnt, m_cnt); end
      checks++; if (last !== (m_cnt == 1) || empty !== (m_cnt == 0)) begin
        errors++; $display("FAIL rnd_flags[%0d]: last=%b empty=%b cnt_model=%0d", n, last, empty, m_cnt);
      end
`ifdef SHIFT_SHADOW_EN
      checks++; if (shv !== m_shv) begin errors++; $display("FAIL rnd_shv[%0d]: got %b want %b", n, shv, m_shv); end
`endif
    end
    clrn = 1'b1; inh = 1'b0; latch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_inhibit();
    test_clear_and_async_reset();
    test_serial_fill();
    test_reload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
